// File: rtl/la_tiebank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : la_tiebank_pkg
// Purpose  : Shared types and limits for the la_tiebank tie-value bank.
//            Holds the control state enumeration and the largest supported
//            bank width.
// Revision : 1.0 - initial release
// ============================================================================
package la_tiebank_pkg;

   // Largest number of tie outputs a single bank may drive.
   localparam int unsigned MAX_N = 64;

   // Control states. IDLE/SHIFT/READY mirror the shift counter
   // (0, partial, full); LOCKED freezes the bank until reset.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      READY  = 2'd2,
      LOCKED = 2'd3
   } state_e;

endpackage : la_tiebank_pkg
`default_nettype wire

// File: rtl/la_tiebank_sr.sv
`default_nettype none
// ============================================================================
// Module   : la_tiebank_sr
// Purpose  : N-bit serial shift chain with a saturating bit counter.
//            Bits enter at the MSB and leave at the LSB. The counter
//            records how many bits have been shifted in, saturating at N.
// Ports    : clk         - clock, rising edge
//            reset       - synchronous active-high reset
//            shift_i     - shift si_i into the chain
//            si_i        - serial data in
//            load_i      - parallel load of load_val_i, counter -> N
//            load_val_i  - parallel load value
//            clr_i       - clear the counter (highest priority after reset)
//            sr_o        - chain contents
//            cnt_o       - bits shifted since last clear
// Revision : 1.0 - initial release
// ============================================================================
module la_tiebank_sr #(
   parameter int             N        = 8,
   parameter logic [N-1:0]   RESETVAL = '0,
   parameter string          PROP     = "DEFAULT"
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     shift_i,
   input  logic                     si_i,
   input  logic                     load_i,
   input  logic [N-1:0]             load_val_i,
   input  logic                     clr_i,
   output logic [N-1:0]             sr_o,
   output logic [$clog2(N+1)-1:0]   cnt_o
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(N);

   logic [N-1:0]  sr_q, sr_d, shifted;
   logic [CW-1:0] cnt_q, cnt_d;

   // The implementation property carries no function; an empty string
   // simply selects the generic implementation like any other value.
   if (PROP == "") begin : g_prop_generic
   end

   // A one-bit chain has no upper slice to shift down.
   if (N == 1) begin : g_shift_one
      assign shifted = si_i;
   end else begin : g_shift_multi
      assign shifted = {si_i, sr_q[N-1:1]};
   end

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         sr_d  = load_val_i;
         cnt_d = CNT_MAX;
      end else if (shift_i) begin
         sr_d  = shifted;
         cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= RESETVAL;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign sr_o  = sr_q;
   assign cnt_o = cnt_q;

endmodule : la_tiebank_sr
`default_nettype wire

// File: rtl/la_tiebank.sv
`default_nettype none
// ============================================================================
// Module   : la_tiebank
// Purpose  : Serially loaded, lockable bank of N registered tie values.
//            Bits are shifted into a chain, then transferred to z by a
//            single-cycle update once exactly N bits (or more) are in.
//            An update with a short chain sets the sticky err flag. lock
//            freezes z until reset.
// Macro    : LA_TIEBANK_CAPTURE_EN - adds the capture port, which loads z
//            back into the chain for serial readback on so.
// Ports    : clk, reset (sync, active-high), shift_en, si, so, update,
//            lock, capture (macro only), z[N-1:0], locked, err
// Revision : 1.0 - initial release
// ============================================================================
module la_tiebank
   import la_tiebank_pkg::*;
#(
   parameter int           N        = 8,
   parameter logic [N-1:0] RESETVAL = '0,
   parameter string        PROP     = "DEFAULT"
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         shift_en,
   input  logic         si,
   output logic         so,
   input  logic         update,
   input  logic         lock,
`ifdef LA_TIEBANK_CAPTURE_EN
   input  logic         capture,
`endif
   output logic [N-1:0] z,
   output logic         locked,
   output logic         err
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   if (N < 1 || N > int'(MAX_N)) begin : g_bad_n
      $error("la_tiebank: N out of range");
   end

   state_e        state_q;
   logic [N-1:0]  z_q;
   logic          locked_q, err_q;
   logic [N-1:0]  w_sr;
   logic [CW-1:0] w_cnt;
   logic          w_cap_in, w_active, w_cap, w_shf, w_clr, w_cnt_last;

`ifdef LA_TIEBANK_CAPTURE_EN
   assign w_cap_in = capture;
`else
   assign w_cap_in = 1'b0;
`endif

   // Priority outside LOCKED: update > lock > capture > shift. Entering
   // LOCKED also clears the counter and drops any shift/capture that cycle.
   assign w_active   = (state_q != LOCKED);
   assign w_clr      = w_active & (update | lock);
   assign w_cap      = w_active & w_cap_in & ~update & ~lock;
   assign w_shf      = w_active & shift_en & ~w_cap_in & ~update & ~lock;
   assign w_cnt_last = (w_cnt >= CNT_LAST);

   la_tiebank_sr #(
      .N        (N),
      .RESETVAL (RESETVAL),
      .PROP     (PROP)
   ) u_sr (
      .clk        (clk),
      .reset      (reset),
      .shift_i    (w_shf),
      .si_i       (si),
      .load_i     (w_cap),
      .load_val_i (z_q),
      .clr_i      (w_clr),
      .sr_o       (w_sr),
      .cnt_o      (w_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         z_q      <= RESETVAL;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else if (w_active) begin
         if (update) begin
            if (state_q == READY) z_q   <= w_sr;
            else                  err_q <= 1'b1;
         end
         if (lock) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
         end else if (update) begin
            state_q <= IDLE;
         end else if (w_cap) begin
            state_q <= READY;
         end else if (w_shf) begin
            // After this shift the counter reaches (or stays at) N.
            state_q <= w_cnt_last ? READY : SHIFT;
         end
      end
   end

   assign so     = w_sr[0];
   assign z      = z_q;
   assign locked = locked_q;
   assign err    = err_q;

endmodule : la_tiebank
`default_nettype wire
